// File: rtl/reflet_mmio_serial_tx.sv
// Memory-mapped serial transmitter: 4-word register window, byte FIFO, start/LSB-first data/stop framing.
// Define REFLET_SERIAL_TX_PARITY_EN to add a parity bit (CTRL bit2 selects odd) between data and stop.
module reflet_mmio_serial_tx #(
    parameter int unsigned             addr_size   = 8,
    parameter logic [addr_size-1:0]    base_addr   = addr_size'(8'hF0),
    parameter int unsigned             word_size   = 8,
    parameter int unsigned             fifo_depth  = 4,
    parameter int unsigned             clk_per_bit = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addr_size-1:0] addr,
    input  logic [word_size-1:0] data_in,
    input  logic                 write_en,
    output logic [word_size-1:0] data_out,
    output logic                 tx,
    output logic                 irq
);
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(clk_per_bit);
    localparam int NW = $clog2(word_size);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic [BW-1:0]        baud;
    logic [NW-1:0]        bitn;
    logic [word_size-1:0] shift;

    logic                 ctrl_en, ctrl_flush, ctrl_odd;
    logic [word_size-1:0] drop_cnt;

    logic [word_size-1:0] mem [fifo_depth];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;

    logic       sel, wr_data, wr_ctrl, wr_drop, flush_now;
    logic       fifo_empty, fifo_full, busy, push, pop, drop, baud_last;
    logic [1:0] off;
    logic [2:0] cnt_sat;

    assign sel        = addr[addr_size-1:2] == base_addr[addr_size-1:2];
    assign off        = addr[1:0];
    assign wr_data    = sel & write_en & (off == 2'd0);
    assign wr_ctrl    = sel & write_en & (off == 2'd2);
    assign wr_drop    = sel & write_en & (off == 2'd3);
    assign flush_now  = wr_ctrl & data_in[1];

    assign fifo_empty = count == '0;
    assign fifo_full  = count == CW'(fifo_depth);
    assign busy       = state != S_IDLE;
    assign baud_last  = baud == BW'(clk_per_bit - 1);
    // Pop decision uses the registered count, so a push into an empty FIFO is seen one cycle later.
    assign pop        = (state == S_IDLE) & ctrl_en & !fifo_empty & !flush_now;
    assign push       = wr_data & (!fifo_full | pop);
    assign drop       = wr_data & fifo_full & !pop;
    assign cnt_sat    = (int'(count) > 7) ? 3'd7 : 3'(count);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef REFLET_SERIAL_TX_PARITY_EN
    logic par;
`else
    assign ctrl_odd = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            ctrl_flush <= 1'b0;
`ifdef REFLET_SERIAL_TX_PARITY_EN
            ctrl_odd   <= 1'b0;
`endif
            drop_cnt   <= '0;
            irq        <= 1'b0;
        end else begin
            ctrl_flush <= 1'b0;
            if (wr_ctrl) begin
                ctrl_en    <= data_in[0];
                ctrl_flush <= data_in[1];
`ifdef REFLET_SERIAL_TX_PARITY_EN
                ctrl_odd   <= data_in[2];
`endif
            end
            if (wr_drop)
                drop_cnt <= '0;
            else if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            irq <= ctrl_en & !fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            tx    <= 1'b1;
            baud  <= '0;
            bitn  <= '0;
            shift <= '0;
`ifdef REFLET_SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
`ifdef REFLET_SERIAL_TX_PARITY_EN
                        par   <= (^mem[rd_ptr]) ^ ctrl_odd;
`endif
                        baud  <= '0;
                        bitn  <= '0;
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud  <= '0;
                        tx    <= shift[0];
                        state <= S_DATA;
                    end else baud <= baud + 1'b1;
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bitn == NW'(word_size - 1)) begin
`ifdef REFLET_SERIAL_TX_PARITY_EN
                            tx    <= par;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            shift <= shift >> 1;
                            tx    <= shift[1];
                            bitn  <= bitn + 1'b1;
                        end
                    end else baud <= baud + 1'b1;
                end
`ifdef REFLET_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else baud <= baud + 1'b1;
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= S_IDLE;
                    end else baud <= baud + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !sel) begin
            data_out <= '0;
        end else begin
            case (off)
                2'd1:    data_out <= word_size'({cnt_sat, busy, fifo_full, fifo_empty});
                2'd2:    data_out <= word_size'({ctrl_odd, ctrl_flush, ctrl_en});
                2'd3:    data_out <= drop_cnt;
                default: data_out <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_mmio_serial_tx.sv
// Scoreboard bench for reflet_mmio_serial_tx: queued register reads and serial frames checked by monitors.
module tb_reflet_mmio_serial_tx;
    localparam int CPB = 4;
`ifdef REFLET_SERIAL_TX_PARITY_EN
    localparam int FW = 11;
`else
    localparam int FW = 10;
`endif
    localparam int FRAME_CYC = FW * CPB + 1;
    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0, reset = 1'b1, write_en = 1'b0, rd_req = 1'b0;
    logic [7:0] addr = 8'h00, data_in = 8'h00;
    logic [7:0] data_out;
    logic       tx, irq;

    always #5 clk = ~clk;

    reflet_mmio_serial_tx #(
        .addr_size(8), .base_addr(8'hF0), .word_size(8), .fifo_depth(4), .clk_per_bit(CPB)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write_en(write_en),
        .data_out(data_out), .tx(tx), .irq(irq)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [FW-1:0] exp_fq[$];
    int            start_q[$];
    logic [7:0]    rd_exp_q[$];
    string         rd_name_q[$];
    logic          aborted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [7:0] d, input logic p);
`ifdef REFLET_SERIAL_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, d, 1'b0} | FW'(p & 1'b0);
`endif
    endfunction

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        @(negedge clk);
        addr = BASE | {6'b0, off}; data_in = d; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0; addr = 8'h00;
    endtask

    task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string name);
        @(negedge clk);
        addr = BASE | {6'b0, off}; rd_req = 1'b1;
        rd_exp_q.push_back(exp); rd_name_q.push_back(name);
        @(negedge clk);
        rd_req = 1'b0; addr = 8'h00;
    endtask

    // Read monitor: data_out is valid right after the edge that sampled the read address.
    always @(posedge clk) begin
        if (rd_req) begin
            #1;
            if (rd_exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_unexpected: got %0h, expected no read", data_out);
            end else begin
                chk(rd_name_q.pop_front(), {24'h0, data_out}, {24'h0, rd_exp_q.pop_front()});
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            if (reset) aborted = 1'b1;
        end
    endtask

    // Frame monitor: samples each bit half a cycle into its period; a reset mid-frame discards it.
    initial begin : txmon
        logic [FW-1:0] fr;
        forever begin
            @(negedge clk); #1;
            if (!reset && tx === 1'b0) begin
                aborted = 1'b0;
                fr = '0;
                fr[0] = tx;
                start_q.push_back(cyc);
                for (int i = 1; i < FW && !aborted; i++) begin
                    wait_n(CPB);
                    fr[i] = tx;
                end
                if (!aborted) begin
                    if (exp_fq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL tx_unexpected_frame: got %0h, expected no frame", fr);
                    end else begin
                        chk("tx_frame", 32'(fr), 32'(exp_fq.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("tx_reset", 32'(tx), 32'd1);
        chk("irq_reset", 32'(irq), 32'd0);
        chk("dout_reset", 32'(data_out), 32'd0);
        rd(2'd1, 8'h01, "status_reset");
        rd(2'd3, 8'h00, "drop_reset");

        // Single byte: start 0, A5 LSB first, stop 1.
        wr(2'd2, 8'h01);
`ifdef REFLET_SERIAL_TX_PARITY_EN
        exp_fq.push_back(mk(8'hA5, 1'b0));
`else
        exp_fq.push_back(10'b1101001010);
`endif
        wr(2'd0, 8'hA5);
        chk("tx_latency_1", 32'(tx), 32'd1);
        @(negedge clk);
        chk("tx_latency_2", 32'(tx), 32'd0);
        chk("irq_enabled", 32'(irq), 32'd1);
        rd(2'd1, 8'h05, "status_busy");
        repeat (FRAME_CYC + 10) @(negedge clk);

        // Fill while disabled: two drops, then drain in order.
        wr(2'd2, 8'h00);
        for (int i = 0; i < 6; i++) wr(2'd0, 8'h11 + 8'(i));
        exp_fq.push_back(mk(8'h11, 1'b0));
        exp_fq.push_back(mk(8'h12, 1'b0));
        exp_fq.push_back(mk(8'h13, 1'b1));
        exp_fq.push_back(mk(8'h14, 1'b0));
        rd(2'd1, 8'h22, "status_full");
        rd(2'd3, 8'h02, "drop_count");
        chk("irq_full", 32'(irq), 32'd0);
        start_q.delete();
        wr(2'd2, 8'h01);
        repeat (4 * FRAME_CYC + 20) @(negedge clk);
        rd(2'd1, 8'h01, "status_drained");
        chk("burst_frame_count", 32'(start_q.size()), 32'd4);
        if (start_q.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("frame_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME_CYC));
        chk("irq_drained", 32'(irq), 32'd1);
        wr(2'd3, 8'h00);
        rd(2'd3, 8'h00, "drop_cleared");

        // Flush during first frame: second byte never sent.
        exp_fq.push_back(mk(8'h21, 1'b0));
        wr(2'd0, 8'h21);
        wr(2'd0, 8'h22);
        wr(2'd2, 8'h03);
        rd(2'd2, 8'h01, "ctrl_after_flush");
        rd(2'd1, 8'h05, "status_flushed");
        repeat (FRAME_CYC + 20) @(negedge clk);
        rd(2'd1, 8'h01, "status_after_flush");

        // Reset in the middle of the data bits.
        wr(2'd0, 8'h33);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("tx_reset_mid", 32'(tx), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rd(2'd1, 8'h01, "status_after_reset");
        rd(2'd2, 8'h00, "ctrl_after_reset");
        chk("irq_after_reset", 32'(irq), 32'd0);
        repeat (FRAME_CYC) @(negedge clk);

        wr(2'd2, 8'h01);
`ifdef REFLET_SERIAL_TX_PARITY_EN
        exp_fq.push_back({1'b1, 1'b1, 8'h07, 1'b0});
        wr(2'd0, 8'h07);
        repeat (FRAME_CYC + 10) @(negedge clk);
        wr(2'd2, 8'h05);
        rd(2'd2, 8'h05, "ctrl_odd");
        exp_fq.push_back({1'b1, 1'b0, 8'h07, 1'b0});
        wr(2'd0, 8'h07);
        repeat (FRAME_CYC + 10) @(negedge clk);
`else
        wr(2'd2, 8'h05);
        rd(2'd2, 8'h01, "ctrl_no_parity");
        exp_fq.push_back(10'b1000001110);
        wr(2'd0, 8'h07);
        repeat (FRAME_CYC + 10) @(negedge clk);
`endif
        chk("frames_left", 32'(exp_fq.size()), 32'd0);
        chk("reads_left", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
